// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - fetch PC register with redirect, stall buffering and exception entry
// Owns the architectural IF-stage PC; redirects seen during a stall are held until release.
module next_pc_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h0000_4180),
  parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(32'h0000_3000),
  parameter int                IMEM_BYTES = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic [1:0]        pc_sel_i,
  input  logic              cmp_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic [25:0]       instr_index_i,
  input  logic [31:0]       imm_i,
  input  logic [ADDR_W-1:0] rs_val_i,
  input  logic              exc_req_i,
  input  logic              eret_req_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pending_o,
  output logic              fetch_adel_o
);

  // One extra bit so a window ending exactly at 2^ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0]   IMEM_END = {1'b0, IMEM_BASE} + (ADDR_W+1)'(IMEM_BYTES);
  localparam logic [ADDR_W-1:0] LOW28    = ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] pc_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_pc_q;

  logic [ADDR_W+31:0] imm_wide;
  logic [ADDR_W-1:0]  imm_ext;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  br_pc;
  logic [ADDR_W-1:0]  jmp_pc;
  logic [ADDR_W-1:0]  redir_pc;
  logic               redir_vld;

  assign imm_wide = {{ADDR_W{imm_i[31]}}, imm_i};
  assign imm_ext  = imm_wide[ADDR_W-1:0];
  assign seq_pc   = pc_q + ADDR_W'(4);
  assign br_pc    = id_pc_i + ADDR_W'(4) + {imm_ext[ADDR_W-3:0], 2'b00};
  assign jmp_pc   = (id_pc_i & ~LOW28) | ADDR_W'({instr_index_i, 2'b00});

  always_comb begin
    redir_vld = 1'b0;
    redir_pc  = seq_pc;
    case (pc_sel_i)
      2'd1: begin
        redir_vld = cmp_i;
        redir_pc  = br_pc;
      end
      2'd2: begin
        redir_vld = 1'b1;
        redir_pc  = jmp_pc;
      end
      2'd3: begin
        redir_vld = 1'b1;
        redir_pc  = rs_val_i;
      end
      default: begin
        redir_vld = 1'b0;
        redir_pc  = seq_pc;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
    end else if (exc_req_i) begin
      pc_q   <= EXC_VEC;
      pend_q <= 1'b0;
    end else if (eret_req_i) begin
      pc_q   <= epc_i;
      pend_q <= 1'b0;
    end else if (stall_i) begin
      // Newest redirect wins the buffer; the PC itself stays frozen.
      if (redir_vld) begin
        pend_q    <= 1'b1;
        pend_pc_q <= redir_pc;
      end
    end else if (redir_vld) begin
      pc_q   <= redir_pc;
      pend_q <= 1'b0;
    end else if (pend_q) begin
      pc_q   <= pend_pc_q;
      pend_q <= 1'b0;
    end else begin
      pc_q <= seq_pc;
    end
  end

  assign pc_o         = pc_q;
  assign pending_o    = pend_q;
  assign fetch_adel_o = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) ||
                        ({1'b0, pc_q} >= IMEM_END);

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed and randomized checks of next_pc_unit against a reference model
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic [1:0]  pc_sel_i;
  logic        cmp_i;
  logic [31:0] id_pc_i;
  logic [25:0] instr_index_i;
  logic [31:0] imm_i;
  logic [31:0] rs_val_i;
  logic        exc_req_i;
  logic        eret_req_i;
  logic [31:0] epc_i;
  logic [31:0] pc_o;
  logic        pending_o;
  logic        fetch_adel_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_pc;

  next_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .pc_sel_i     (pc_sel_i),
    .cmp_i        (cmp_i),
    .id_pc_i      (id_pc_i),
    .instr_index_i(instr_index_i),
    .imm_i        (imm_i),
    .rs_val_i     (rs_val_i),
    .exc_req_i    (exc_req_i),
    .eret_req_i   (eret_req_i),
    .epc_i        (epc_i),
    .pc_o         (pc_o),
    .pending_o    (pending_o),
    .fetch_adel_o (fetch_adel_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h3000 + 32'd16384);
  endfunction

  task automatic idle();
    stall_i = 0; pc_sel_i = 0; cmp_i = 0; exc_req_i = 0; eret_req_i = 0;
  endtask

  // Advance one clock: model consumes the inputs present at the edge, then DUT is compared.
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    redir = (pc_sel_i == 2'd1 && cmp_i) || (pc_sel_i >= 2'd2);
    case (pc_sel_i)
      2'd1:    tgt = id_pc_i + 32'd4 + imm_i * 32'd4;
      2'd2:    tgt = (id_pc_i & 32'hF000_0000) + {4'b0, instr_index_i, 2'b00};
      default: tgt = rs_val_i;
    endcase
    if (exc_req_i) begin
      m_pc = 32'h4180; m_pend = 0;
    end else if (eret_req_i) begin
      m_pc = epc_i; m_pend = 0;
    end else if (stall_i) begin
      if (redir) begin m_pend = 1; m_pend_pc = tgt; end
    end else if (redir) begin
      m_pc = tgt; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_pend_pc; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check("model_pc", pc_o, m_pc);
    check("model_pend", {31'b0, pending_o}, {31'b0, m_pend});
    check("model_adel", {31'b0, fetch_adel_o}, {31'b0, model_adel(m_pc)});
  endtask

  initial begin
    idle();
    id_pc_i = 0; instr_index_i = 0; imm_i = 0; rs_val_i = 0; epc_i = 0;
    reset = 1;
    m_pc = 32'h3000; m_pend = 0; m_pend_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc_o, 32'h3000);
    check("reset_pend", {31'b0, pending_o}, 32'd0);
    check("reset_adel", {31'b0, fetch_adel_o}, 32'd0);
    @(negedge clk);
    reset = 0;

    step(); check("seq1", pc_o, 32'h3004);
    step(); check("seq2", pc_o, 32'h3008);
    step(); check("seq3", pc_o, 32'h300C);

    pc_sel_i = 1; id_pc_i = 32'h3008; imm_i = 32'hFFFF_FFFE; cmp_i = 1;
    step(); check("br_taken", pc_o, 32'h3004);
    cmp_i = 0;
    step(); check("br_not_taken", pc_o, 32'h3008);

    idle(); stall_i = 1; pc_sel_i = 3; rs_val_i = 32'h3100;
    step(); check("stall_jr_hold", pc_o, 32'h3008);
    check("stall_jr_pend", {31'b0, pending_o}, 32'd1);
    pc_sel_i = 0;
    step(); step(); check("stall_hold3", pc_o, 32'h3008);
    stall_i = 0;
    step(); check("jr_release", pc_o, 32'h3100);
    check("jr_release_pend", {31'b0, pending_o}, 32'd0);

    stall_i = 1; pc_sel_i = 2; id_pc_i = 32'h3000; instr_index_i = 26'h0C80;
    step(); check("jmp_pend", {31'b0, pending_o}, 32'd1);
    pc_sel_i = 0; exc_req_i = 1;
    step(); check("exc_in_stall", pc_o, 32'h4180);
    check("exc_clears_pend", {31'b0, pending_o}, 32'd0);
    idle();
    step(); check("exc_discard", pc_o, 32'h4184);

    exc_req_i = 1; eret_req_i = 1; epc_i = 32'h3050;
    step(); check("exc_beats_eret", pc_o, 32'h4180);
    exc_req_i = 0;
    step(); check("eret", pc_o, 32'h3050);

    idle(); pc_sel_i = 3; rs_val_i = 32'h3102;
    step(); check("adel_misaligned", {31'b0, fetch_adel_o}, 32'd1);
    rs_val_i = 32'h7000;
    step(); check("adel_top", {31'b0, fetch_adel_o}, 32'd1);
    rs_val_i = 32'h6FFC;
    step(); check("adel_last_ok", {31'b0, fetch_adel_o}, 32'd0);
    rs_val_i = 32'h2FFC;
    step(); check("adel_below", {31'b0, fetch_adel_o}, 32'd1);

    stall_i = 1; rs_val_i = 32'h3400;
    step();
    idle();
    #2 reset = 1;
    #1;
    check("async_reset_pc", pc_o, 32'h3000);
    check("async_reset_pend", {31'b0, pending_o}, 32'd0);
    m_pc = 32'h3000; m_pend = 0;
    @(negedge clk);
    reset = 0;
    step(); check("post_reset_seq", pc_o, 32'h3004);

    for (int i = 0; i < 600; i++) begin
      stall_i       = ($urandom_range(0, 9) < 3);
      pc_sel_i      = 2'($urandom_range(0, 3));
      cmp_i         = 1'($urandom_range(0, 1));
      id_pc_i       = 32'h3000 + $urandom_range(0, 4095) * 4;
      instr_index_i = 26'($urandom);
      imm_i         = $urandom_range(0, 64) - 32;
      rs_val_i      = ($urandom_range(0, 9) == 0) ? $urandom
                                                  : 32'h3000 + $urandom_range(0, 4095) * 4;
      exc_req_i     = ($urandom_range(0, 31) == 0);
      eret_req_i    = ($urandom_range(0, 31) == 0);
      epc_i         = 32'h3000 + $urandom_range(0, 4095) * 4;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
